// File: rtl/regdst_pkg.sv
// Shared register-destination encodings and constants, used by the control unit
// and by the destination-tracking pipeline.
package regdst_pkg;

  typedef enum logic [1:0] {
    REG_DST_RT   = 2'b00,
    REG_DST_RD   = 2'b01,
    REG_DST_RA   = 2'b10,
    REG_DST_NONE = 2'b11
  } reg_dst_e;

  localparam int REG_ZERO        = 0;
  localparam int RA_ADDR_DEFAULT = 31;

endpackage

// File: rtl/regdst_track_pipe_dst_match.sv
// Finds the youngest valid pipeline stage whose destination equals a source register.
// Register zero never matches.
module dst_match
  import regdst_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3
) (
  input  logic [ADDR_W-1:0]       i_q,
  input  logic [DEPTH*ADDR_W-1:0] i_stageDst,
  input  logic [DEPTH-1:0]        i_stageVld,
  output logic [DEPTH-1:0]        o_oh,
  output logic                    o_hit
);

  logic [DEPTH-1:0] w_match;
  logic             w_qNonZero;

  assign w_qNonZero = (i_q != ADDR_W'(REG_ZERO));

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign w_match[g] = i_stageVld[g] && w_qNonZero &&
                        (i_stageDst[g*ADDR_W +: ADDR_W] == i_q);
  end

  // Isolating the lowest set bit keeps only the youngest matching stage.
  assign o_oh  = w_match & (~w_match + DEPTH'(1));
  assign o_hit = |w_match;

endmodule

// File: rtl/regdst_track_pipe.sv
// Selects the write-destination register and tracks it through DEPTH stages,
// driving the register-file write port and rs/rt hazard detection.
module regdst_track_pipe
  import regdst_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 3,
  parameter int RA_ADDR = RA_ADDR_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    reg_write,
  input  logic [1:0]              reg_dst,
  input  logic [ADDR_W-1:0]       rt,
  input  logic [ADDR_W-1:0]       rd,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [ADDR_W-1:0]       rs_q,
  input  logic [ADDR_W-1:0]       rt_q,
  output logic [ADDR_W-1:0]       write_register,
  output logic [DEPTH*ADDR_W-1:0] stage_dst,
  output logic [DEPTH-1:0]        stage_vld,
  output logic [ADDR_W-1:0]       wb_dst,
  output logic                    wb_we,
  output logic [DEPTH-1:0]        hz_rs_oh,
  output logic [DEPTH-1:0]        hz_rt_oh,
  output logic                    hz_rs_hit,
  output logic                    hz_rt_hit
);

  logic [ADDR_W-1:0] w_writeRegister;
  logic              w_newVld;

  // The "no write" encoding still presents rt so the mux output is always defined.
  always_comb begin
    w_writeRegister = rt;
    case (reg_dst_e'(reg_dst))
      REG_DST_RT:   w_writeRegister = rt;
      REG_DST_RD:   w_writeRegister = rd;
      REG_DST_RA:   w_writeRegister = ADDR_W'(RA_ADDR);
      REG_DST_NONE: w_writeRegister = rt;
      default:      w_writeRegister = rt;
    endcase
  end

  assign write_register = w_writeRegister;
  assign w_newVld = in_valid && reg_write &&
                    (reg_dst_e'(reg_dst) != REG_DST_NONE) &&
                    (w_writeRegister != ADDR_W'(REG_ZERO));

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [ADDR_W-1:0] r_dst;
    logic              r_vld;
    logic [ADDR_W-1:0] w_dIn;
    logic              w_vIn;

    if (g == 0) begin : g_head
      assign w_dIn = w_writeRegister;
      assign w_vIn = w_newVld;
    end else begin : g_body
      assign w_dIn = g_stage[g-1].r_dst;
      assign w_vIn = g_stage[g-1].r_vld;
    end

    // Flush only clears valid bits; destinations hold until the next advance.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_dst <= '0;
        r_vld <= 1'b0;
      end else if (flush) begin
        r_vld <= 1'b0;
      end else if (!stall) begin
        r_dst <= w_dIn;
        r_vld <= w_vIn;
      end
    end

    assign stage_dst[g*ADDR_W +: ADDR_W] = r_dst;
    assign stage_vld[g]                  = r_vld;
  end

  assign wb_dst = stage_dst[(DEPTH-1)*ADDR_W +: ADDR_W];
  assign wb_we  = stage_vld[DEPTH-1];

  dst_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rsMatch (
    .i_q        (rs_q),
    .i_stageDst (stage_dst),
    .i_stageVld (stage_vld),
    .o_oh       (hz_rs_oh),
    .o_hit      (hz_rs_hit)
  );

  dst_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rtMatch (
    .i_q        (rt_q),
    .i_stageDst (stage_dst),
    .i_stageVld (stage_vld),
    .o_oh       (hz_rt_oh),
    .o_hit      (hz_rt_hit)
  );

endmodule
